// File: rtl/ea_pkg.sv
// Shared definitions for the ISA I/O write capture block: the decoded
// register addresses, the command target and FSM state encodings, and a
// helper that classifies one host write.
package ea_pkg;

  // Host I/O addresses of the two 16-bit registers, written low byte first
  localparam logic [15:0] ADDR_CTL_LO = 16'h7CA6;
  localparam logic [15:0] ADDR_CTL_HI = 16'h7CA7;
  localparam logic [15:0] ADDR_CHN_LO = 16'h7C94;
  localparam logic [15:0] ADDR_CHN_HI = 16'h7C95;

  // Which register a byte pair is assembling
  typedef enum logic {
    TGT_CTL = 1'b0,
    TGT_CHN = 1'b1
  } target_e;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_HI = 2'd1,
    STROBE  = 2'd2
  } state_e;

  // One classified host write; valid is clear for ignored cycles
  typedef struct packed {
    logic       valid;
    logic       is_hi;
    target_e    tgt;
    logic [7:0] data;
  } capture_t;

  // Classify a host write; hit qualifies the write as a real I/O capture
  function automatic capture_t decode_capture(input logic        hit,
                                              input logic [15:0] addr,
                                              input logic [7:0]  data);
    capture_t c;
    c.valid = 1'b0;
    c.is_hi = 1'b0;
    c.tgt   = TGT_CTL;
    c.data  = data;
    case (addr)
      ADDR_CTL_LO: begin
        c.valid = hit;
      end
      ADDR_CTL_HI: begin
        c.valid = hit;
        c.is_hi = 1'b1;
      end
      ADDR_CHN_LO: begin
        c.valid = hit;
        c.tgt   = TGT_CHN;
      end
      ADDR_CHN_HI: begin
        c.valid = hit;
        c.is_hi = 1'b1;
        c.tgt   = TGT_CHN;
      end
      default: begin
        c.valid = 1'b0;
      end
    endcase
    return c;
  endfunction

endpackage

// File: rtl/ea_sync.sv
// Multi-flop synchronizer for an asynchronous active-low strobe. Flops reset
// to 1 so the strobe reads inactive while and right after reset.
module ea_sync #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic async_in,
  output logic sync_out
);

  // Fewer than two flops gives no metastability protection, so clamp
  localparam int STAGES = (DEPTH < 2) ? 2 : DEPTH;

  logic [STAGES-1:0] sync_ff;

  // Shift the raw input through the chain; the last flop is the safe copy
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_ff <= '1;
    end else begin
      sync_ff <= {sync_ff[STAGES-2:0], async_in};
    end
  end

  assign sync_out = sync_ff[STAGES-1];

endmodule

// File: rtl/ea_iowr_capture.sv
// Captures pairs of 8-bit ISA host writes (low byte, then high byte) into a
// 16-bit command word and announces each completed word with a one-cycle
// strobe for the control or channel-enable register. Out-of-order bytes and
// a missing high byte are reported on seq_err.
module ea_iowr_capture
  import ea_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] isa_addr,
  input  logic [7:0]  isa_data,
  input  logic        isa_iow_n,
  input  logic        isa_aen,
  output logic [15:0] cmd,
  output logic        addr7CA6,
  output logic        addr7C94,
  output logic        seq_err
);

  // The timer holds the cycles already spent waiting; a high byte may arrive
  // up to TIMEOUT_CYC cycles after its low byte, so the wait gives up in the
  // cycle where the count would pass TIMEOUT_CYC-1 without a high byte.
  localparam int TIMER_W        = (TIMEOUT_CYC < 1) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int TIMER_LAST_INT = (TIMEOUT_CYC < 1) ? 0 : TIMEOUT_CYC - 1;
  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMER_LAST_INT);

  logic               iow_sync;
  logic               iow_prev;
  logic               capture_hit;
  capture_t           cap_now;
  capture_t           defer_q;
  capture_t           proc;
  state_e             state;
  target_e            tgt_q;
  logic [7:0]         lo_reg;
  logic [TIMER_W-1:0] timer;

  ea_sync #(
    .DEPTH (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .reset_n  (reset_n),
    .async_in (isa_iow_n),
    .sync_out (iow_sync)
  );

  // Remember the previous synchronized level to find the falling edge
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      iow_prev <= 1'b1;
    end else begin
      iow_prev <= iow_sync;
    end
  end

  // A capture is a synchronized 1->0 edge of the strobe outside DMA cycles;
  // address and data are taken in that same cycle.
  assign capture_hit = iow_prev & ~iow_sync & ~isa_aen;
  assign cap_now     = decode_capture(capture_hit, isa_addr, isa_data);

  // A capture parked during STROBE is replayed in the following IDLE cycle.
  // The synchronizer needs a high cycle between edges, so a fresh capture
  // can never collide with the replayed one.
  assign proc = defer_q.valid ? defer_q : cap_now;

  // Byte-pair sequencer with registered strobe and error outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      tgt_q    <= TGT_CTL;
      lo_reg   <= 8'h00;
      timer    <= '0;
      cmd      <= 16'h0000;
      addr7CA6 <= 1'b0;
      addr7C94 <= 1'b0;
      seq_err  <= 1'b0;
      defer_q  <= '0;
    end else begin
      addr7CA6      <= 1'b0;
      addr7C94      <= 1'b0;
      seq_err       <= 1'b0;
      defer_q.valid <= 1'b0;
      case (state)
        IDLE: begin
          if (proc.valid) begin
            if (proc.is_hi) begin
              seq_err <= 1'b1;
            end else begin
              lo_reg <= proc.data;
              tgt_q  <= proc.tgt;
              timer  <= '0;
              state  <= WAIT_HI;
            end
          end
        end
        WAIT_HI: begin
          if (proc.valid) begin
            if (!proc.is_hi) begin
              lo_reg <= proc.data;
              tgt_q  <= proc.tgt;
              timer  <= '0;
            end else if (proc.tgt == tgt_q) begin
              cmd   <= {proc.data, lo_reg};
              state <= STROBE;
              if (tgt_q == TGT_CTL) begin
                addr7CA6 <= 1'b1;
              end else begin
                addr7C94 <= 1'b1;
              end
            end else begin
              seq_err <= 1'b1;
              lo_reg  <= 8'h00;
              state   <= IDLE;
            end
          end else if (timer == TIMER_LAST) begin
            seq_err <= 1'b1;
            lo_reg  <= 8'h00;
            state   <= IDLE;
          end else begin
            timer <= timer + TIMER_W'(1);
          end
        end
        STROBE: begin
          defer_q <= cap_now;
          state   <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ea_iowr_capture.sv
// Self-checking bench for ea_iowr_capture: directed scenarios plus a random
// host write stream compared against a transaction-level model.
module tb_ea_iowr_capture;

  localparam int T = 40;
  localparam int S = 2;
  localparam logic [15:0] A_CTL_LO = 16'h7CA6;
  localparam logic [15:0] A_CTL_HI = 16'h7CA7;
  localparam logic [15:0] A_CHN_LO = 16'h7C94;
  localparam logic [15:0] A_CHN_HI = 16'h7C95;
  localparam int EV_CTL = 0;
  localparam int EV_CHN = 1;
  localparam int EV_ERR = 2;

  logic        clk;
  logic        reset_n;
  logic [15:0] isa_addr;
  logic [7:0]  isa_data;
  logic        isa_iow_n;
  logic        isa_aen;
  logic [15:0] cmd;
  logic        addr7CA6;
  logic        addr7C94;
  logic        seq_err;

  typedef struct {
    int          kind;
    logic [15:0] val;
  } ev_t;

  int          n_cmp = 0;
  int          n_fail = 0;
  int          cyc = 0;
  ev_t         obs_q[$];
  ev_t         exp_q[$];
  int          cnt_ctl = 0;
  int          cnt_chn = 0;
  int          cnt_err = 0;
  logic [15:0] prev_cmd = 16'h0000;

  bit          m_pend;
  int          m_tgt;
  logic [7:0]  m_lo;
  int          m_t;
  logic [15:0] m_cmd;

  ea_iowr_capture #(
    .TIMEOUT_CYC (T),
    .SYNC_STAGES (S)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .isa_addr  (isa_addr),
    .isa_data  (isa_data),
    .isa_iow_n (isa_iow_n),
    .isa_aen   (isa_aen),
    .cmd       (cmd),
    .addr7CA6  (addr7CA6),
    .addr7C94  (addr7C94),
    .seq_err   (seq_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Record every output pulse and check the always-true output rules
  always @(negedge clk) begin
    ev_t e;
    if (reset_n) begin
      if (addr7CA6) begin cnt_ctl++; e.kind = EV_CTL; e.val = cmd; obs_q.push_back(e); end
      if (addr7C94) begin cnt_chn++; e.kind = EV_CHN; e.val = cmd; obs_q.push_back(e); end
      if (seq_err)  begin cnt_err++; e.kind = EV_ERR; e.val = '0;  obs_q.push_back(e); end
      if (addr7CA6 | addr7C94 | seq_err) begin
        n_cmp++;
        if ((int'(addr7CA6) + int'(addr7C94) + int'(seq_err)) != 1) begin
          n_fail++;
          $display("[TB] FAIL exclusive_outputs: got ctl=%b chn=%b err=%b, need exactly one high",
                   addr7CA6, addr7C94, seq_err);
        end
      end
      if (cmd !== prev_cmd) begin
        n_cmp++;
        if (!(addr7CA6 | addr7C94)) begin
          n_fail++;
          $display("[TB] FAIL cmd_hold: cmd changed %h -> %h without a strobe", prev_cmd, cmd);
        end
      end
    end
    prev_cmd = cmd;
  end

  // Transaction-level reference: pending low byte with its capture time
  function automatic void model_reset();
    m_pend = 1'b0;
    m_cmd  = 16'h0000;
    exp_q.delete();
  endfunction

  function automatic void model_write(input logic [15:0] a, input logic [7:0] d,
                                      input logic aen, input int t);
    int  tgt;
    bit  hi;
    ev_t e;
    if (aen) return;
    if      (a == A_CTL_LO) begin tgt = EV_CTL; hi = 1'b0; end
    else if (a == A_CTL_HI) begin tgt = EV_CTL; hi = 1'b1; end
    else if (a == A_CHN_LO) begin tgt = EV_CHN; hi = 1'b0; end
    else if (a == A_CHN_HI) begin tgt = EV_CHN; hi = 1'b1; end
    else return;
    if (m_pend && (t - m_t) > T) begin
      e.kind = EV_ERR; e.val = '0; exp_q.push_back(e); m_pend = 1'b0;
    end
    if (!hi) begin
      m_pend = 1'b1; m_tgt = tgt; m_lo = d; m_t = t;
    end else if (m_pend && m_tgt == tgt) begin
      m_cmd = {d, m_lo}; e.kind = tgt; e.val = m_cmd; exp_q.push_back(e); m_pend = 1'b0;
    end else begin
      e.kind = EV_ERR; e.val = '0; exp_q.push_back(e); m_pend = 1'b0;
    end
  endfunction

  function automatic void model_flush(input int t);
    ev_t e;
    if (m_pend && (t - m_t) > T) begin
      e.kind = EV_ERR; e.val = '0; exp_q.push_back(e); m_pend = 1'b0;
    end
  endfunction

  function automatic void clear_counts();
    cnt_ctl = 0; cnt_chn = 0; cnt_err = 0;
    obs_q.delete();
  endfunction

  // One host write; consecutive writes start low_cyc+high_cyc cycles apart
  task automatic host_write(input logic [15:0] a, input logic [7:0] d, input logic aen,
                            input int low_cyc, input int high_cyc);
    @(negedge clk);
    isa_addr  = a;
    isa_data  = d;
    isa_aen   = aen;
    isa_iow_n = 1'b0;
    model_write(a, d, aen, cyc);
    repeat (low_cyc) @(negedge clk);
    isa_iow_n = 1'b1;
    repeat (high_cyc - 1) @(negedge clk);
  endtask

  task automatic do_reset(input int n);
    @(negedge clk);
    reset_n = 1'b0;
    repeat (n) @(negedge clk);
    reset_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    n_cmp += 4;
    if (cmd !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_cmd: got %h need 0000", cmd); end
    if (addr7CA6 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_ctl: got %b need 0", addr7CA6); end
    if (addr7C94 !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_chn: got %b need 0", addr7C94); end
    if (seq_err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b need 0", seq_err); end
    reset_n = 1'b1;
    model_reset();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_ctl_write();
    logic [8:0]  pulse;
    logic [8:0]  exp_pulse;
    logic [15:0] cmd_at;
    clear_counts();
    host_write(A_CTL_LO, 8'h01, 1'b0, 2, 4);
    @(negedge clk);
    isa_addr = A_CTL_HI; isa_data = 8'h00; isa_aen = 1'b0; isa_iow_n = 1'b0;
    pulse = '0;
    cmd_at = 16'hxxxx;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 2) isa_iow_n = 1'b1;
      pulse[k] = addr7CA6;
      if (k == S + 1) cmd_at = cmd;
    end
    exp_pulse = 9'd1 << (S + 1);
    n_cmp += 4;
    if (pulse !== exp_pulse) begin n_fail++; $display("[TB] FAIL ctl_strobe_timing: got %b need %b", pulse, exp_pulse); end
    if (cmd_at !== 16'h0001) begin n_fail++; $display("[TB] FAIL ctl_cmd_in_strobe: got %h need 0001", cmd_at); end
    if (cnt_chn !== 0) begin n_fail++; $display("[TB] FAIL ctl_no_chn: got %0d need 0", cnt_chn); end
    if (cnt_err !== 0) begin n_fail++; $display("[TB] FAIL ctl_no_err: got %0d need 0", cnt_err); end
  endtask

  task automatic test_chn_write();
    clear_counts();
    host_write(A_CHN_LO, 8'h10, 1'b0, 2, 4);
    host_write(A_CHN_HI, 8'h00, 1'b0, 2, 4);
    repeat (S + 3) @(negedge clk);
    n_cmp += 4;
    if (cmd !== 16'h0010) begin n_fail++; $display("[TB] FAIL chn_cmd: got %h need 0010", cmd); end
    if (cnt_chn !== 1) begin n_fail++; $display("[TB] FAIL chn_pulses: got %0d need 1", cnt_chn); end
    if (cnt_ctl !== 0) begin n_fail++; $display("[TB] FAIL chn_no_ctl: got %0d need 0", cnt_ctl); end
    if (cnt_err !== 0) begin n_fail++; $display("[TB] FAIL chn_no_err: got %0d need 0", cnt_err); end
  endtask

  task automatic test_timeout();
    logic [15:0] cmd_before;
    cmd_before = cmd;
    clear_counts();
    host_write(A_CHN_LO, 8'h02, 1'b0, 2, 2);
    repeat (T + 5) @(negedge clk);
    n_cmp++;
    if (cnt_err !== 1) begin n_fail++; $display("[TB] FAIL timeout_err: got %0d need 1", cnt_err); end
    host_write(A_CHN_HI, 8'h00, 1'b0, 2, 2);
    repeat (S + 3) @(negedge clk);
    n_cmp += 3;
    if (cnt_err !== 2) begin n_fail++; $display("[TB] FAIL orphan_err: got %0d need 2", cnt_err); end
    if ((cnt_ctl + cnt_chn) !== 0) begin n_fail++; $display("[TB] FAIL timeout_no_strobe: got %0d need 0", cnt_ctl + cnt_chn); end
    if (cmd !== cmd_before) begin n_fail++; $display("[TB] FAIL timeout_cmd: got %h need %h", cmd, cmd_before); end
  endtask

  task automatic test_timeout_boundary();
    clear_counts();
    host_write(A_CTL_LO, 8'h5A, 1'b0, 1, T - 1);
    host_write(A_CTL_HI, 8'hA5, 1'b0, 1, 3);
    repeat (S + 3) @(negedge clk);
    n_cmp += 3;
    if (cnt_ctl !== 1) begin n_fail++; $display("[TB] FAIL edge_in_time_strobe: got %0d need 1", cnt_ctl); end
    if (cnt_err !== 0) begin n_fail++; $display("[TB] FAIL edge_in_time_err: got %0d need 0", cnt_err); end
    if (cmd !== 16'hA55A) begin n_fail++; $display("[TB] FAIL edge_in_time_cmd: got %h need a55a", cmd); end
    clear_counts();
    host_write(A_CTL_LO, 8'h11, 1'b0, 1, T);
    host_write(A_CTL_HI, 8'h22, 1'b0, 1, 3);
    repeat (S + 3) @(negedge clk);
    n_cmp += 3;
    if (cnt_ctl !== 0) begin n_fail++; $display("[TB] FAIL edge_late_strobe: got %0d need 0", cnt_ctl); end
    if (cnt_err !== 2) begin n_fail++; $display("[TB] FAIL edge_late_err: got %0d need 2", cnt_err); end
    if (cmd !== 16'hA55A) begin n_fail++; $display("[TB] FAIL edge_late_cmd: got %h need a55a", cmd); end
  endtask

  task automatic test_wrong_target_and_aen();
    logic [15:0] cmd_before;
    cmd_before = cmd;
    clear_counts();
    host_write(A_CTL_LO, 8'h01, 1'b0, 2, 2);
    host_write(A_CHN_HI, 8'h00, 1'b0, 2, 2);
    host_write(A_CTL_LO, 8'h55, 1'b1, 2, 2);
    host_write(A_CTL_HI, 8'h66, 1'b1, 2, 2);
    repeat (S + 3) @(negedge clk);
    n_cmp += 3;
    if (cnt_err !== 1) begin n_fail++; $display("[TB] FAIL wrong_tgt_err: got %0d need 1", cnt_err); end
    if ((cnt_ctl + cnt_chn) !== 0) begin n_fail++; $display("[TB] FAIL wrong_tgt_strobe: got %0d need 0", cnt_ctl + cnt_chn); end
    if (cmd !== cmd_before) begin n_fail++; $display("[TB] FAIL aen_cmd: got %h need %h", cmd, cmd_before); end
    host_write(A_CTL_HI, 8'h77, 1'b0, 2, 2);
    repeat (S + 3) @(negedge clk);
    n_cmp += 2;
    if (cnt_err !== 2) begin n_fail++; $display("[TB] FAIL aen_ignored_err: got %0d need 2", cnt_err); end
    if (cnt_ctl !== 0) begin n_fail++; $display("[TB] FAIL aen_ignored_strobe: got %0d need 0", cnt_ctl); end
    host_write(A_CTL_LO, 8'h01, 1'b0, 2, 2);
    host_write(16'h1234, 8'hAA, 1'b0, 2, 2);
    host_write(A_CTL_HI, 8'h22, 1'b0, 2, 2);
    repeat (S + 3) @(negedge clk);
    n_cmp += 2;
    if (cnt_ctl !== 1) begin n_fail++; $display("[TB] FAIL undecoded_strobe: got %0d need 1", cnt_ctl); end
    if (cmd !== 16'h2201) begin n_fail++; $display("[TB] FAIL undecoded_cmd: got %h need 2201", cmd); end
  endtask

  task automatic test_reset_mid_sequence();
    clear_counts();
    host_write(A_CHN_LO, 8'h01, 1'b0, 2, 2);
    do_reset(3);
    repeat (6) @(negedge clk);
    n_cmp++;
    if ((cnt_ctl + cnt_chn + cnt_err) !== 0) begin n_fail++; $display("[TB] FAIL release_quiet: got %0d pulses need 0", cnt_ctl + cnt_chn + cnt_err); end
    host_write(A_CHN_HI, 8'h00, 1'b0, 2, 2);
    repeat (S + 3) @(negedge clk);
    n_cmp += 3;
    if (cnt_err !== 1) begin n_fail++; $display("[TB] FAIL mid_reset_err: got %0d need 1", cnt_err); end
    if (cnt_chn !== 0) begin n_fail++; $display("[TB] FAIL mid_reset_strobe: got %0d need 0", cnt_chn); end
    if (cmd !== 16'h0000) begin n_fail++; $display("[TB] FAIL mid_reset_cmd: got %h need 0000", cmd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] exp_val [3];
    int          exp_kind [3];
    clear_counts();
    host_write(A_CTL_LO, 8'h11, 1'b0, 2, 1);
    host_write(A_CTL_HI, 8'h22, 1'b0, 2, 1);
    host_write(A_CHN_LO, 8'h33, 1'b0, 2, 1);
    host_write(A_CHN_HI, 8'h44, 1'b0, 2, 1);
    host_write(A_CTL_LO, 8'h55, 1'b0, 2, 1);
    host_write(A_CTL_HI, 8'h66, 1'b0, 2, 1);
    repeat (S + 3) @(negedge clk);
    exp_kind[0] = EV_CTL; exp_val[0] = 16'h2211;
    exp_kind[1] = EV_CHN; exp_val[1] = 16'h4433;
    exp_kind[2] = EV_CTL; exp_val[2] = 16'h6655;
    n_cmp++;
    if (obs_q.size() != 3) begin
      n_fail++;
      $display("[TB] FAIL b2b_count: got %0d events need 3", obs_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (obs_q[i].kind != exp_kind[i] || obs_q[i].val !== exp_val[i]) begin
          n_fail++;
          $display("[TB] FAIL b2b_event%0d: got kind %0d cmd %h need kind %0d cmd %h",
                   i, obs_q[i].kind, obs_q[i].val, exp_kind[i], exp_val[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [7:0]  d;
    logic        aen;
    int          r;
    int          gap;
    int          lo;
    int          n;
    do_reset(2);
    repeat (3) @(negedge clk);
    clear_counts();
    for (int i = 0; i < 200; i++) begin
      r = $urandom_range(0, 99);
      if      (r < 22) a = A_CTL_LO;
      else if (r < 44) a = A_CHN_LO;
      else if (r < 66) a = A_CTL_HI;
      else if (r < 88) a = A_CHN_HI;
      else             a = 16'($urandom);
      aen = ($urandom_range(0, 9) == 0);
      d   = 8'($urandom);
      gap = ($urandom_range(0, 7) == 0) ? $urandom_range(T + 5, T + 20) : $urandom_range(3, T / 2);
      lo  = $urandom_range(1, 2);
      host_write(a, d, aen, lo, gap - lo);
    end
    repeat (T + 10) @(negedge clk);
    model_flush(cyc);
    n_cmp++;
    if (obs_q.size() != exp_q.size()) begin
      n_fail++;
      $display("[TB] FAIL rand_count: got %0d events need %0d", obs_q.size(), exp_q.size());
    end
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      n_cmp++;
      if (obs_q[i].kind != exp_q[i].kind ||
          (exp_q[i].kind != EV_ERR && obs_q[i].val !== exp_q[i].val)) begin
        n_fail++;
        $display("[TB] FAIL rand_event%0d: got kind %0d cmd %h need kind %0d cmd %h",
                 i, obs_q[i].kind, obs_q[i].val, exp_q[i].kind, exp_q[i].val);
      end
    end
    n_cmp++;
    if (cmd !== m_cmd) begin n_fail++; $display("[TB] FAIL rand_final_cmd: got %h need %h", cmd, m_cmd); end
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    isa_addr  = 16'h0000;
    isa_data  = 8'h00;
    isa_iow_n = 1'b1;
    isa_aen   = 1'b0;
    model_reset();
    $display("[TB] start");
    test_reset();
    test_ctl_write();
    test_chn_write();
    test_timeout();
    test_timeout_boundary();
    test_wrong_target_and_aen();
    test_reset_mid_sequence();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ea_iowr_capture.md
EA_IOWR_CAPTURE -- requirements
Module: ea_iowr_capture

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: max clk cycles from low-byte capture to high-byte capture.
REQ-002 SHALL have parameter SYNC_STAGES, default 2: flip-flop depth of the isa_iow_n synchronizer (min 2).
REQ-003 clk  input  1  single system clock; all logic on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 isa_addr  input  16  host I/O address; stable for the whole isa_iow_n low period.
REQ-006 isa_data  input  8  host write data; stable for the whole isa_iow_n low period.
REQ-007 isa_iow_n  input  1  asynchronous host I/O write strobe, active low.
REQ-008 isa_aen  input  1  DMA address enable; 1 = cycle not for I/O decode.
REQ-009 cmd  output  16  assembled command word {high byte, low byte}; held between strobes.
REQ-010 addr7CA6  output  1  one-cycle strobe: cmd valid for control register 0x7CA6.
REQ-011 addr7C94  output  1  one-cycle strobe: cmd valid for channel-enable register 0x7C94.
REQ-012 seq_err  output  1  one-cycle pulse on a byte-sequence error or timeout.

Function
REQ-013 isa_iow_n SHALL pass through a SYNC_STAGES flip-flop synchronizer before any use; a capture event is a synchronized 1->0 transition.
REQ-014 On a capture event with isa_aen=0, isa_addr and isa_data SHALL be sampled in that same cycle; when isa_aen=1, the event SHALL be ignored.
REQ-015 Decoded addresses: 0x7CA6 = CTL low, 0x7CA7 = CTL high, 0x7C94 = CHN low, 0x7C95 = CHN high; all other addresses SHALL be ignored with no state change.
REQ-016 FSM states: IDLE, WAIT_HI, STROBE.
REQ-017 IDLE + low-byte capture: store byte in lo_reg, record target (CTL/CHN), clear timer, go to WAIT_HI.
REQ-018 IDLE + high-byte capture: stay in IDLE and pulse seq_err.
REQ-019 WAIT_HI + high-byte capture for the recorded target: load cmd = {data, lo_reg} and go to STROBE.
REQ-020 WAIT_HI + high-byte capture for the other target: pulse seq_err, discard the pending low byte, go to IDLE.
REQ-021 WAIT_HI + low-byte capture (either target): replace lo_reg and target, restart timer, pulse no error.
REQ-022 WAIT_HI timer SHALL increment each cycle; on reaching TIMEOUT_CYC with no high byte, pulse seq_err and go to IDLE.
REQ-023 STROBE: assert addr7CA6 or addr7C94 (per target) for exactly one cycle, then go to IDLE unconditionally.
REQ-024 Latency: strobe SHALL be high in the cycle immediately after the high-byte capture cycle; cmd SHALL already hold the new value in that cycle.
REQ-025 addr7CA6 and addr7C94 SHALL never be high simultaneously; seq_err SHALL never coincide with a strobe.
REQ-026 cmd SHALL change only on the REQ-019 transition.
REQ-027 A capture event arriving in STROBE SHALL be processed as if in IDLE in the following cycle (no loss; one-cycle deferral register).
REQ-028 Timer width SHALL be clog2(TIMEOUT_CYC+1) bits and SHALL NOT wrap.

Reset
REQ-029 While reset_n=0: FSM=IDLE, cmd=16'h0000, lo_reg=0, timer=0, addr7CA6=0, addr7C94=0, seq_err=0, synchronizer flops=1 (strobe inactive).
REQ-030 Reset asserted mid-sequence SHALL discard any pending low byte; no strobe or seq_err SHALL be produced on release.

Structure
REQ-031 A shared package (ea_pkg) SHALL hold the four address constants, the target enum {TGT_CTL, TGT_CHN}, and the FSM state enum.
REQ-032 The synchronizer SHALL be a separate sub-module ea_sync (parameterized depth, reset value 1).

Verification
REQ-033 Write 0x01 @0x7CA6 then 0x00 @0x7CA7 -> cmd=16'h0001, addr7CA6 high for exactly one cycle, one cycle after the second capture.
REQ-034 Write 0x10 @0x7C94 then 0x00 @0x7C95 -> cmd=16'h0010, one addr7C94 pulse, addr7CA6 remains 0.
REQ-035 Write 0x02 @0x7C94, wait TIMEOUT_CYC+5 cycles, then write 0x00 @0x7C95 -> seq_err pulse at timeout, second seq_err at the orphan high byte, no strobe, cmd unchanged.
REQ-036 Write 0x01 @0x7CA6 then 0x00 @0x7C95 -> seq_err pulse, no strobe; write with isa_aen=1 to 0x7CA6/0x7CA7 -> no effect.
REQ-037 Write 0x01 @0x7C94, assert reset_n=0 for 3 cycles, release, then write 0x00 @0x7C95 -> seq_err only, cmd=0.
REQ-038 Back-to-back: high-byte capture in a STROBE cycle (min strobe spacing) -> both sequences complete, two strobes, no loss.
